// File: rtl/sram_burst_ctrl_if.sv
// Burst command / write-beat / read-beat bundle between the DDR FSM (master)
// and sram_burst_ctrl (slave).
interface sram_burst_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2048,
    parameter int LENW  = 3
);
    localparam int AW = $clog2(DEPTH);

    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_wr;
    logic [AW-1:0]    cmd_addr;
    logic [LENW-1:0]  cmd_len;

    logic             wr_valid;
    logic             wr_ready;
    logic [WIDTH-1:0] wr_data;

    logic             rd_valid;
    logic             rd_ready;
    logic [WIDTH-1:0] rd_data;

    modport master (
        output cmd_valid, cmd_wr, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
        input  cmd_ready, wr_ready, rd_valid, rd_data
    );

    modport slave (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
        output cmd_ready, wr_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/sram_burst_ctrl.sv
// Burst sequencer in front of a single-port block RAM with one-cycle
// registered read. One SRAM access per cycle; read data is absorbed by a
// 2-entry FIFO so the consumer may stall at any time.
// Optional macro SRAM_BURST_WRAP_EN: burst addresses wrap inside the aligned
// 2^LENW block (DDR sequential wrap) instead of incrementing linearly.
module sram_burst_ctrl #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 2048,
    parameter  int LENW  = 3,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    sram_burst_ctrl_if.slave bus,
    output logic             busy,
    output logic [AW-1:0]    sram_addr,
    output logic             sram_rd_o_wr,
    output logic [WIDTH-1:0] sram_i_data,
    input  logic [WIDTH-1:0] sram_o_data
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

    state_t          state;
    logic            cmd_ready_q;
    logic            wr_ready_q;
    logic            busy_q;
    logic [AW-1:0]   cur;
    logic [AW-1:0]   last_addr;
    logic [LENW-1:0] len_q;
    logic [LENW-1:0] beat;
    logic            inflight;

    logic [1:0][WIDTH-1:0] fifo;
    logic            wr_ptr;
    logic            rd_ptr;
    logic [1:0]      occ;

    logic            wr_acc;
    logic            rd_issue;
    logic            push;
    logic            pop;
    logic            room;

    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
`ifdef SRAM_BURST_WRAP_EN
        next_addr = {a[AW-1:LENW], a[LENW-1:0] + LENW'(1)};
`else
        next_addr = (a == AW'(DEPTH - 1)) ? '0 : a + AW'(1);
`endif
    endfunction

    // Accesses are gated by rst_n so nothing reaches the RAM on a reset edge.
    assign push     = inflight;
    assign pop      = bus.rd_valid && bus.rd_ready;
    assign room     = (3'(occ) + 3'(inflight)) < (3'd2 + 3'(pop));
    assign wr_acc   = rst_n && wr_ready_q && bus.wr_valid;
    assign rd_issue = rst_n && (state == READ) && room;

    assign sram_rd_o_wr  = wr_acc;
    assign sram_addr     = (wr_acc || rd_issue) ? cur : last_addr;
    assign sram_i_data   = bus.wr_data;

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.wr_ready  = wr_ready_q;
    assign bus.rd_valid  = (occ != 2'd0);
    assign bus.rd_data   = fifo[rd_ptr];
    assign busy          = busy_q;

    // Burst FSM: latches the command, walks addresses, issues accesses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cmd_ready_q <= 1'b1;
            wr_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            cur         <= '0;
            last_addr   <= '0;
            len_q       <= '0;
            beat        <= '0;
            inflight    <= 1'b0;
        end else begin
            inflight <= rd_issue;
            if (wr_acc || rd_issue)
                last_addr <= cur;
            case (state)
                IDLE: begin
                    if (bus.cmd_valid && cmd_ready_q) begin
                        cur         <= bus.cmd_addr;
                        len_q       <= bus.cmd_len;
                        beat        <= '0;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        wr_ready_q  <= bus.cmd_wr;
                        state       <= bus.cmd_wr ? WRITE : READ;
                    end
                end
                WRITE: begin
                    if (wr_acc) begin
                        cur  <= next_addr(cur);
                        beat <= beat + LENW'(1);
                        if (beat == len_q) begin
                            state       <= IDLE;
                            cmd_ready_q <= 1'b1;
                            wr_ready_q  <= 1'b0;
                            busy_q      <= 1'b0;
                        end
                    end
                end
                READ: begin
                    if (rd_issue) begin
                        cur  <= next_addr(cur);
                        beat <= beat + LENW'(1);
                        if (beat == len_q)
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // inflight==0 also means no push is due this edge
                    if (occ == 2'd0 && !inflight) begin
                        state       <= IDLE;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Response FIFO: captures RAM data one cycle after each read issue.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fifo   <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                fifo[wr_ptr] <= sram_o_data;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Scoreboard bench for sram_burst_ctrl: a behavioural RAM plus a reference
// memory predict every RAM write (address, data) and every read beat.
module tb_sram_burst_ctrl;
    localparam int WIDTH = 8;
    localparam int DEPTH = 2048;
    localparam int LENW  = 3;
    localparam int AW    = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             busy;
    logic [AW-1:0]    sram_addr;
    logic             sram_rd_o_wr;
    logic [WIDTH-1:0] sram_i_data;
    logic [WIDTH-1:0] sram_o_data;

    sram_burst_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LENW(LENW)) bif ();

    sram_burst_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LENW(LENW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bif),
        .busy         (busy),
        .sram_addr    (sram_addr),
        .sram_rd_o_wr (sram_rd_o_wr),
        .sram_i_data  (sram_i_data),
        .sram_o_data  (sram_o_data)
    );

    always #5 clk = ~clk;

    // Behavioural storage: write on edge, registered read.
    logic [WIDTH-1:0] sram [DEPTH];
    bit               sram_init;
    always @(posedge clk) begin
        if (!sram_init) begin
            for (int i = 0; i < DEPTH; i++) sram[i] <= WIDTH'(i * 37 + 5);
            sram_init <= 1'b1;
        end else begin
            if (sram_rd_o_wr) sram[sram_addr] <= sram_i_data;
            sram_o_data <= sram[sram_addr];
        end
    end

    logic [WIDTH-1:0] ref_mem [DEPTH];
    int exp_wa [$];
    int exp_wd [$];
    int exp_rd [$];
    int checks = 0;
    int errors = 0;
    int rd_pops = 0;
    int rd_mode = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    function automatic int baddr(input int base, input int k);
`ifdef SRAM_BURST_WRAP_EN
        return (base & ~((1 << LENW) - 1)) | ((base + k) & ((1 << LENW) - 1));
`else
        return (base + k) % DEPTH;
`endif
    endfunction

    // Monitor: pops expected read beats / RAM writes as the DUT presents them.
    bit               stall_prev;
    logic [WIDTH-1:0] hold_data;
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("rd_hold_valid", 32'(bif.rd_valid), 32'd1);
                check("rd_hold_data", 32'(bif.rd_data), 32'(hold_data));
            end
            if (bif.rd_valid && bif.rd_ready) begin
                if (exp_rd.size() == 0) fail_now("rd_unexpected_beat");
                else check("rd_data", 32'(bif.rd_data), 32'(exp_rd.pop_front()));
                rd_pops++;
            end
            stall_prev = bif.rd_valid && !bif.rd_ready;
            hold_data  = bif.rd_data;
            if (sram_rd_o_wr) begin
                if (exp_wa.size() == 0) begin
                    fail_now("sram_unexpected_write");
                end else begin
                    check("sram_wr_addr", 32'(sram_addr), 32'(exp_wa.pop_front()));
                    check("sram_wr_data", 32'(sram_i_data), 32'(exp_wd.pop_front()));
                end
            end
        end
    end

    // Consumer: rd_ready pattern chosen by rd_mode (0 high, 1 toggle, 2 random).
    initial begin
        bif.rd_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rd_mode)
                0:       bif.rd_ready = 1'b1;
                1:       bif.rd_ready = !bif.rd_ready;
                default: bif.rd_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic send_cmd(input bit wr, input int addr, input int len);
        bit ok = 1'b0;
        bif.cmd_valid = 1'b1;
        bif.cmd_wr    = wr;
        bif.cmd_addr  = AW'(addr);
        bif.cmd_len   = LENW'(len);
        if (!wr)
            for (int k = 0; k <= len; k++) exp_rd.push_back(int'(ref_mem[baddr(addr, k)]));
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (busy) check("cmd_ready_while_busy", 32'(bif.cmd_ready), 32'd0);
            if (bif.cmd_ready) begin ok = 1'b1; break; end
        end
        if (!ok) fail_now("cmd_accept_timeout");
        @(posedge clk); #1;
        bif.cmd_valid = 1'b0;
    endtask

    // gap < 0: random 0..2 idle cycles before each beat; else gap before beats k>0.
    task automatic write_beats(input int addr, input int len, input int gap,
                               input bit chk_first, input logic [WIDTH-1:0] base);
        for (int k = 0; k <= len; k++) begin
            int ng;
            int a;
            bit ok;
            logic [WIDTH-1:0] d;
            ng = (gap < 0) ? int'($urandom_range(0, 2)) : ((k > 0) ? gap : 0);
            bif.wr_valid = 1'b0;
            repeat (ng) begin @(posedge clk); #1; end
            a = baddr(addr, k);
            d = base + WIDTH'(k);
            bif.wr_valid = 1'b1;
            bif.wr_data  = d;
            exp_wa.push_back(a);
            exp_wd.push_back(int'(d));
            ref_mem[a] = d;
            ok = 1'b0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (k == 0 && i == 0 && chk_first)
                    check("wr_first_cycle_ready", 32'(bif.wr_ready), 32'd1);
                if (bif.wr_ready) begin ok = 1'b1; break; end
            end
            if (!ok) fail_now("wr_beat_timeout");
            @(posedge clk); #1;
        end
        bif.wr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy && exp_rd.size() == 0) begin ok = 1'b1; break; end
        end
        if (!ok) fail_now("idle_timeout");
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        bit ok;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = WIDTH'(i * 37 + 5);
        rst_n         = 1'b0;
        bif.cmd_valid = 1'b1;   // held through reset; must not be taken
        bif.cmd_wr    = 1'b1;
        bif.cmd_addr  = '0;
        bif.cmd_len   = '0;
        bif.wr_valid  = 1'b0;
        bif.wr_data   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", 32'(bif.cmd_ready), 32'd1);
        check("rst_wr_ready", 32'(bif.wr_ready), 32'd0);
        check("rst_rd_valid", 32'(bif.rd_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sram_wr", 32'(sram_rd_o_wr), 32'd0);
        check("rst_sram_addr", 32'(sram_addr), 32'd0);
        check("rst_rd_data", 32'(bif.rd_data), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bif.cmd_valid = 1'b0;
        @(negedge clk);
        check("no_accept_in_reset", 32'(busy), 32'd0);
        @(posedge clk); #1;

        // 4-beat write then read back, checking first-access latency
        rd_mode = 0;
        send_cmd(1'b1, 'h010, 3);
        write_beats('h010, 3, 0, 1'b1, 8'hA0);
        wait_idle();
        send_cmd(1'b0, 'h010, 3);
        @(negedge clk); check("rd_lat_c1", 32'(bif.rd_valid), 32'd0);
        @(posedge clk); #1;
        @(negedge clk); check("rd_lat_c2", 32'(bif.rd_valid), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rd_lat_c3_valid", 32'(bif.rd_valid), 32'd1);
        check("rd_lat_c3_data", 32'(bif.rd_data), 32'hA0);
        @(posedge clk); #1;
        wait_idle();
        @(negedge clk); check("busy_after_read", 32'(busy), 32'd0);
        @(posedge clk); #1;

        // toggling consumer
        rd_mode = 1;
        send_cmd(1'b0, 'h020, 7);
        wait_idle();

        // wrap boundary with a 2-cycle write gap, then read back
        rd_mode = 0;
        send_cmd(1'b1, 'h7FF, 1);
        write_beats('h7FF, 1, 2, 1'b0, 8'h5A);
        wait_idle();
        send_cmd(1'b0, 'h7FF, 1);
        wait_idle();

        // read crossing an aligned 8-word block
        rd_mode = 1;
        send_cmd(1'b0, 'h00D, 7);
        wait_idle();

        // reset during beat 2 of a long read
        rd_mode = 0;
        p0 = rd_pops;
        send_cmd(1'b0, 'h030, 7);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rd_pops >= p0 + 2) begin ok = 1'b1; break; end
        end
        if (!ok) fail_now("beat2_timeout");
        rst_n = 1'b0;
        exp_rd.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_rd_valid", 32'(bif.rd_valid), 32'd0);
        check("abort_cmd_ready", 32'(bif.cmd_ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        send_cmd(1'b0, 'h030, 7);
        wait_idle();

        // back-to-back commands: second waits until the first has drained
        rd_mode = 2;
        send_cmd(1'b0, 'h040, 3);
        send_cmd(1'b0, 'h050, 1);
        wait_idle();

        // randomized bursts
        for (int n = 0; n < 40; n++) begin
            bit wr;
            int addr;
            int len;
            wr      = 1'($urandom_range(0, 1));
            addr    = int'($urandom_range(0, DEPTH - 1));
            len     = int'($urandom_range(0, (1 << LENW) - 1));
            rd_mode = int'($urandom_range(0, 2));
            send_cmd(wr, addr, len);
            if (wr) write_beats(addr, len, -1, 1'b0, WIDTH'($urandom));
            wait_idle();
        end

        repeat (4) @(posedge clk);
        #1;
        check("wr_queue_empty", 32'(exp_wa.size()), 32'd0);
        check("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
